// File: rtl/chip_vector_tester.sv
// Table-driven DIP pin-vector sequencer: fetches {drive, oe, expect, care} words from a
// registered ROM, drives the socket, waits a settle interval and compares the synchronised readback.
module chip_vector_tester #(
  parameter int N_IO   = 12,
  parameter int N_VEC  = 16,
  parameter int SETTLE = 4,
  localparam int AW    = (N_VEC > 1) ? $clog2(N_VEC) : 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Run,
  input  logic              stop_on_fail,
  input  logic [AW:0]       num_vec,
  output logic [AW-1:0]     vec_addr,
  input  logic [4*N_IO-1:0] vec_data,
  output logic [N_IO-1:0]   pin_out,
  output logic [N_IO-1:0]   pin_oe,
  input  logic [N_IO-1:0]   pin_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [AW:0]       err_count,
  output logic [AW-1:0]     fail_idx,
  output logic [N_IO-1:0]   fail_bits
);

  localparam int CW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
  localparam logic [AW:0]   N_MAX       = (AW+1)'(N_VEC);
  localparam logic [AW:0]   ERR_SAT     = {(AW+1){1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_LOAD, ST_SETTLE, ST_CHECK, ST_DONE
  } state_t;

  state_t            state;
  logic [N_IO-1:0]   pin_sync1;
  logic [N_IO-1:0]   pin_s;
  logic              run_d;
  logic [AW:0]       n;
  logic              stop;
  logic [AW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [N_IO-1:0]   exp_r;
  logic [N_IO-1:0]   care_r;

  logic              start;
  logic [AW:0]       n_clamp;
  logic [N_IO-1:0]   mism;
  logic              fail;
  logic              last;
  logic [AW:0]       err_next;

  // Two-flop synchroniser on the asynchronous pad readback, plus the Run edge detector.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pin_sync1 <= {N_IO{1'b0}};
      pin_s     <= {N_IO{1'b0}};
      run_d     <= 1'b0;
    end else begin
      pin_sync1 <= pin_in;
      pin_s     <= pin_sync1;
      run_d     <= Run;
    end
  end

  // Start qualification, vector-count clamp and compare datapath.
  always_comb begin
    start    = Run & ~run_d & ~busy;
    n_clamp  = (num_vec > N_MAX) ? N_MAX : num_vec;
    mism     = (pin_s ^ exp_r) & care_r;
    fail     = |mism;
    last     = ({1'b0, idx} == (n - (AW+1)'(1)));
    if (err_count == ERR_SAT) begin
      err_next = err_count;
    end else begin
      err_next = err_count + (AW+1)'(1);
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      vec_addr  <= {AW{1'b0}};
      pin_out   <= {N_IO{1'b0}};
      pin_oe    <= {N_IO{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= {(AW+1){1'b0}};
      fail_idx  <= {AW{1'b0}};
      fail_bits <= {N_IO{1'b0}};
      n         <= {(AW+1){1'b0}};
      stop      <= 1'b0;
      idx       <= {AW{1'b0}};
      cnt       <= {CW{1'b0}};
      exp_r     <= {N_IO{1'b0}};
      care_r    <= {N_IO{1'b0}};
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // busy still set in DONE only happens for an empty test: finish it one cycle later
          if (state == ST_DONE && busy) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_count == {(AW+1){1'b0}});
          end else if (start) begin
            n         <= n_clamp;
            stop      <= stop_on_fail;
            err_count <= {(AW+1){1'b0}};
            fail_idx  <= {AW{1'b0}};
            fail_bits <= {N_IO{1'b0}};
            done      <= 1'b0;
            pass      <= 1'b0;
            idx       <= {AW{1'b0}};
            busy      <= 1'b1;
            if (n_clamp == {(AW+1){1'b0}}) begin
              state <= ST_DONE;
            end else begin
              vec_addr <= {AW{1'b0}};
              state    <= ST_FETCH;
            end
          end else begin
            state <= state;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          pin_out <= vec_data[4*N_IO-1:3*N_IO];
          pin_oe  <= vec_data[3*N_IO-1:2*N_IO];
          exp_r   <= vec_data[2*N_IO-1:N_IO];
          care_r  <= vec_data[N_IO-1:0];
          cnt     <= SETTLE_LOAD;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == {CW{1'b0}}) begin
            state <= ST_CHECK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_CHECK: begin
          if (fail) begin
            err_count <= err_next;
            if (err_count == {(AW+1){1'b0}}) begin
              fail_idx  <= idx;
              fail_bits <= mism;
            end
          end
          if ((fail && stop) || last) begin
            state   <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= ~fail && (err_count == {(AW+1){1'b0}});
            pin_oe  <= {N_IO{1'b0}};
            pin_out <= {N_IO{1'b0}};
          end else begin
            idx      <= idx + AW'(1);
            vec_addr <= idx + AW'(1);
            state    <= ST_FETCH;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
